// File: rtl/i2c_master_arb.sv
// Round-robin arbiter/sequencer sharing one i2c_master between NREQ single-byte requesters.
// Optional watchdog abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arb #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rd_wr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              rsp_timeout,
    output logic              m_start,
    output logic [6:0]        m_address,
    output logic              m_rd_wr,
    output logic [7:0]        m_din,
    output logic              m_stop,
    output logic              m_abort,
    input  logic [7:0]        m_dout,
    input  logic              m_busy,
    input  logic              m_nack
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    logic [NREQ-1:0][6:0] addr_arr;
    logic [NREQ-1:0][7:0] wdata_arr;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [6:0]    addr_q, addr_d;
    logic          rd_q, rd_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          nack_q, nack_d;
    logic          tmo_q, tmo_d;
    logic          tmo_hit;
    logic          in_wait;

    assign in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_vld && req_valid[GW'(idx)]) begin
                pick_vld = 1'b1;
                pick     = GW'(idx);
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LAUNCH) cnt_d = '0;
        else if (in_wait)      cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tmo_hit = in_wait && (cnt_q == CNT_LAST);
`else
    logic unused_tmo;
    assign unused_tmo = ^CNT_LAST;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        tmo_d       = tmo_q;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_rdata   = 8'h00;
        rsp_nack    = 1'b0;
        rsp_timeout = 1'b0;
        m_start     = 1'b0;
        m_stop      = 1'b0;
        m_abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    addr_d  = addr_arr[pick];
                    rd_d    = req_rd_wr[pick];
                    wdata_d = wdata_arr[pick];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                m_start          = 1'b1;
                m_stop           = 1'b1;
                req_ready[gnt_q] = 1'b1;
                last_d           = gnt_q;
                nack_d           = 1'b0;
                tmo_d            = 1'b0;
                rdata_d          = 8'h00;
                state_d          = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                m_stop = 1'b1;
                nack_d = nack_q | m_nack;
                if (tmo_hit) begin
                    m_abort = 1'b1;
                    tmo_d   = 1'b1;
                    rdata_d = 8'h00;
                    state_d = RESP;
                end else if (state_q == WAIT_BUSY) begin
                    if (m_busy) state_d = WAIT_DONE;
                end else if (!m_busy) begin
                    // A NACK landing on the same edge as busy falling still counts.
                    rdata_d = (rd_q && !nack_q && !m_nack) ? m_dout : 8'h00;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_rdata        = rdata_q;
                rsp_nack         = nack_q;
                rsp_timeout      = tmo_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_address = addr_q;
    assign m_rd_wr   = rd_q;
    assign m_din     = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NREQ - 1);
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_arb.sv
// Self-checking bench for i2c_master_arb: behavioural i2c_master model plus a
// round-robin reference model driven by randomized requests.
module tb_i2c_master_arb;

    localparam int NREQ = 4;
    localparam int TCYC = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [3:0]  req_rd_wr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;
    logic        m_start;
    logic [6:0]  m_address;
    logic        m_rd_wr;
    logic [7:0]  m_din;
    logic        m_stop;
    logic        m_abort;
    logic [7:0]  m_dout;
    logic        m_busy;
    logic        m_nack;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // master model configuration
    int         busy_len = 4;
    int         nack_at  = -1;
    logic [7:0] dout_val = 8'h00;
    bit         stuck    = 1'b0;
    int         drop_cyc = 0;
    int         mcnt;

    typedef struct {
        bit         got_start;
        int         st_cyc;
        logic [3:0] rdy;
        logic [6:0] addr;
        logic       rd;
        logic [7:0] din;
        logic       stop;
        bit         stable;
        bit         got_rsp;
        int         rsp_cyc;
        logic [3:0] vld;
        logic [7:0] rdata;
        logic       nack;
        logic       tmo;
        int         drop_cyc;
        int         abort_cyc;
    } obs_t;

    i2c_master_arb #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_rd_wr(req_rd_wr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .m_start(m_start), .m_address(m_address), .m_rd_wr(m_rd_wr), .m_din(m_din),
        .m_stop(m_stop), .m_abort(m_abort),
        .m_dout(m_dout), .m_busy(m_busy), .m_nack(m_nack)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Behavioural i2c_master: busy rises on start, falls busy_len cycles later.
    initial begin
        m_busy = 1'b0; m_nack = 1'b0; m_dout = 8'h00; mcnt = 0;
        forever begin
            @(negedge clk);
            m_nack = 1'b0;
            if (!rst || m_abort) begin
                m_busy = 1'b0; mcnt = 0;
            end else if (m_start) begin
                m_busy = 1'b1; mcnt = busy_len; m_dout = 8'h00;
            end else if (m_busy && !stuck) begin
                mcnt--;
                if (mcnt == nack_at) m_nack = 1'b1;
                if (mcnt == 0) begin
                    m_busy = 1'b0; m_dout = dout_val; drop_cyc = cyc;
                end
            end
        end
    end

    function automatic logic [36:0] all_outs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, m_start,
                m_address, m_rd_wr, m_din, m_stop, m_abort};
    endfunction

    function automatic int rr_next(input logic [3:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [6:0] a, input logic rd, input logic [7:0] d);
        req_addr[7*i +: 7]  = a;
        req_rd_wr[i]        = rd;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Observes one launch and its response; requester drops valid on ready if drop is set.
    task automatic observe_txn(input bit drop, input int budget, output obs_t o);
        int n;
        o.got_start = 0; o.st_cyc = 0; o.rdy = '0; o.addr = '0; o.rd = 0; o.din = '0;
        o.stop = 0; o.stable = 1; o.got_rsp = 0; o.rsp_cyc = 0; o.vld = '0; o.rdata = '0;
        o.nack = 0; o.tmo = 0; o.drop_cyc = 0; o.abort_cyc = -1;
        n = 0;
        while (!o.got_start && n < 50) begin
            @(negedge clk); n++;
            if (m_start) begin
                o.got_start = 1; o.st_cyc = cyc; o.rdy = req_ready; o.addr = m_address;
                o.rd = m_rd_wr; o.din = m_din; o.stop = m_stop;
                if (drop) req_valid = req_valid & ~req_ready;
            end
        end
        if (!o.got_start) return;
        n = 0;
        while (!o.got_rsp && n < budget) begin
            @(negedge clk); n++;
            if (m_abort) o.abort_cyc = cyc;
            if (rsp_valid != '0) begin
                o.got_rsp = 1; o.rsp_cyc = cyc; o.vld = rsp_valid; o.rdata = rsp_rdata;
                o.nack = rsp_nack; o.tmo = rsp_timeout;
            end else if (m_stop !== 1'b1 || m_address !== o.addr || m_din !== o.din || m_rd_wr !== o.rd) begin
                o.stable = 0;
            end
        end
        o.drop_cyc = drop_cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_addr = '0; req_rd_wr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (all_outs() !== 37'd0) begin n_bad++; $display("FAIL reset_outs got %h want 0", all_outs()); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (all_outs() !== 37'd0) begin n_bad++; $display("FAIL idle_outs got %h want 0", all_outs()); end
    endtask

    task automatic test_single_write();
        obs_t o; int t0;
        busy_len = 20; nack_at = -1; dout_val = 8'h99;
        @(negedge clk);
        set_req(0, 7'h50, 1'b0, 8'hA5); req_valid = 4'b0001; t0 = cyc;
        observe_txn(1, 100, o);
        n_cmp++; if (!o.got_start || o.st_cyc !== t0 + 1) begin n_bad++; $display("FAIL wr_start_lat got %0d want %0d", o.st_cyc - t0, 1); end
        n_cmp++; if (o.rdy !== 4'b0001) begin n_bad++; $display("FAIL wr_ready got %b want 0001", o.rdy); end
        n_cmp++; if ({o.addr, o.rd, o.din, o.stop} !== {7'h50, 1'b0, 8'hA5, 1'b1}) begin n_bad++; $display("FAIL wr_cmd got %h/%b/%h/%b want 50/0/a5/1", o.addr, o.rd, o.din, o.stop); end
        n_cmp++; if (!o.stable) begin n_bad++; $display("FAIL wr_cmd_stable got unstable want stable"); end
        n_cmp++; if (!o.got_rsp || o.vld !== 4'b0001) begin n_bad++; $display("FAIL wr_rsp_valid got %b want 0001", o.vld); end
        n_cmp++; if (o.rsp_cyc !== o.drop_cyc + 1) begin n_bad++; $display("FAIL wr_rsp_lat got %0d want %0d", o.rsp_cyc - o.drop_cyc, 1); end
        n_cmp++; if ({o.nack, o.tmo, o.rdata} !== 10'd0) begin n_bad++; $display("FAIL wr_rsp_fields got %b/%b/%h want 0/0/00", o.nack, o.tmo, o.rdata); end
    endtask

    task automatic test_read();
        obs_t o;
        busy_len = 12; nack_at = -1; dout_val = 8'h7E;
        @(negedge clk);
        set_req(2, 7'h3C, 1'b1, 8'h00); req_valid = 4'b0100;
        observe_txn(1, 100, o);
        n_cmp++; if (o.rdy !== 4'b0100 || o.addr !== 7'h3C || o.rd !== 1'b1) begin n_bad++; $display("FAIL rd_cmd got %b/%h/%b want 0100/3c/1", o.rdy, o.addr, o.rd); end
        n_cmp++; if (o.vld !== 4'b0100 || o.rdata !== 8'h7E) begin n_bad++; $display("FAIL rd_rsp got %b/%h want 0100/7e", o.vld, o.rdata); end
        n_cmp++; if (o.rsp_cyc !== o.drop_cyc + 1) begin n_bad++; $display("FAIL rd_rsp_lat got %0d want %0d", o.rsp_cyc - o.drop_cyc, 1); end
    endtask

    task automatic test_round_robin();
        obs_t o; int prev; int exp[5];
        exp = '{0, 1, 2, 3, 0};
        busy_len = 2; nack_at = -1; dout_val = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 7'(8'h10 + i), 1'b0, 8'(8'hC0 + i));
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        prev = -100;
        for (int k = 0; k < 5; k++) begin
            observe_txn(0, 50, o);
            n_cmp++; if (o.rdy !== (4'b0001 << exp[k]) || o.addr !== 7'(8'h10 + exp[k])) begin n_bad++; $display("FAIL rr_grant%0d got %b/%h want req %0d", k, o.rdy, o.addr, exp[k]); end
            n_cmp++; if (!o.got_rsp || o.vld !== o.rdy) begin n_bad++; $display("FAIL rr_rsp%0d got %b want %b", k, o.vld, o.rdy); end
            if (k > 0) begin
                n_cmp++; if (o.st_cyc - prev < 4) begin n_bad++; $display("FAIL rr_gap%0d got %0d want >=4", k, o.st_cyc - prev); end
            end
            prev = o.st_cyc;
        end
        req_valid = '0;
    endtask

    task automatic test_nack();
        obs_t o;
        int         rq[5] = '{1, 3, 2, 1, 0};
        logic       rd[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int         bl[5] = '{10, 6, 4, 8, 5};
        int         na[5] = '{5, 0, 3, -1, -1};
        logic [7:0] dv[5] = '{8'hC3, 8'h5A, 8'h11, 8'h77, 8'h3E};
        logic [7:0] er;
        for (int k = 0; k < 5; k++) begin
            busy_len = bl[k]; nack_at = na[k]; dout_val = dv[k];
            @(negedge clk);
            set_req(rq[k], 7'(8'h20 + k), rd[k], 8'(k)); req_valid = 4'b0001 << rq[k];
            observe_txn(1, 100, o);
            er = (rd[k] && na[k] < 0) ? dv[k] : 8'h00;
            n_cmp++; if (!o.got_rsp || o.vld !== (4'b0001 << rq[k])) begin n_bad++; $display("FAIL nack_rsp%0d got %b want req %0d", k, o.vld, rq[k]); end
            n_cmp++; if (o.nack !== (na[k] >= 0)) begin n_bad++; $display("FAIL nack_flag%0d got %b want %b", k, o.nack, (na[k] >= 0)); end
            n_cmp++; if (o.rdata !== er) begin n_bad++; $display("FAIL nack_rdata%0d got %h want %h", k, o.rdata, er); end
        end
    endtask

    task automatic test_random();
        obs_t o; int last; int g; logic [3:0] pend;
        logic [6:0] pa[4]; logic pr[4]; logic [7:0] pw[4];
        logic [7:0] er; bit en;
        do_reset();
        last = NREQ - 1; pend = '0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1; pa[i] = 7'($urandom); pr[i] = 1'($urandom); pw[i] = 8'($urandom);
                    set_req(i, pa[i], pr[i], pw[i]);
                end
            if (pend == '0) begin
                pend[0] = 1'b1; pa[0] = 7'($urandom); pr[0] = 1'b1; pw[0] = 8'($urandom);
                set_req(0, pa[0], pr[0], pw[0]);
            end
            busy_len = $urandom_range(2, 10);
            en       = ($urandom_range(0, 3) == 0);
            nack_at  = en ? $urandom_range(0, busy_len - 1) : -1;
            dout_val = 8'($urandom);
            req_valid = pend;
            g = rr_next(pend, last);
            observe_txn(1, 100, o);
            er = (pr[g] && !en) ? dout_val : 8'h00;
            n_cmp++; if (o.rdy !== (4'b0001 << g)) begin n_bad++; $display("FAIL rand%0d_grant got %b want req %0d", t, o.rdy, g); end
            n_cmp++; if ({o.addr, o.rd, o.din} !== {pa[g], pr[g], pw[g]}) begin n_bad++; $display("FAIL rand%0d_cmd got %h/%b/%h want %h/%b/%h", t, o.addr, o.rd, o.din, pa[g], pr[g], pw[g]); end
            n_cmp++; if (!o.got_rsp || o.vld !== (4'b0001 << g) || o.rsp_cyc !== o.drop_cyc + 1) begin n_bad++; $display("FAIL rand%0d_rsp got %b@%0d want req %0d@%0d", t, o.vld, o.rsp_cyc, g, o.drop_cyc + 1); end
            n_cmp++; if (o.rdata !== er || o.nack !== en || !o.stable) begin n_bad++; $display("FAIL rand%0d_data got %h/%b/%b want %h/%b/1", t, o.rdata, o.nack, o.stable, er, en); end
            pend[g] = 1'b0; last = g;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        obs_t o; int n; bit seen; bit bad_rsp;
        do_reset();
        busy_len = 4; nack_at = -1; dout_val = 8'h00;
        @(negedge clk);
        set_req(1, 7'h41, 1'b0, 8'h12); req_valid = 4'b0010;
        observe_txn(1, 100, o);
        busy_len = 30;
        @(negedge clk);
        req_valid = 4'b0010;
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clk); n++;
            if (m_start) begin seen = 1; req_valid = '0; end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (!seen || m_stop !== 1'b1) begin n_bad++; $display("FAIL rstmid_active got start=%b stop=%b want 1/1", seen, m_stop); end
        rst = 1'b0;
        #1;
        n_cmp++; if (all_outs() !== 37'd0) begin n_bad++; $display("FAIL rstmid_outs got %h want 0", all_outs()); end
        bad_rsp = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid != '0) bad_rsp = 1; end
        set_req(0, 7'h0A, 1'b0, 8'h01); set_req(2, 7'h2A, 1'b0, 8'h02);
        req_valid = 4'b0101; busy_len = 3;
        rst = 1'b1;
        observe_txn(1, 100, o);
        n_cmp++; if (bad_rsp) begin n_bad++; $display("FAIL rstmid_norsp got rsp_valid want none"); end
        n_cmp++; if (o.rdy !== 4'b0001 || o.addr !== 7'h0A) begin n_bad++; $display("FAIL rstmid_first got %b/%h want 0001/0a", o.rdy, o.addr); end
        observe_txn(1, 100, o);
        n_cmp++; if (o.rdy !== 4'b0100) begin n_bad++; $display("FAIL rstmid_second got %b want 0100", o.rdy); end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_reset();
        stuck = 1'b1; busy_len = 5; nack_at = -1; dout_val = 8'hEE;
        @(negedge clk);
        set_req(2, 7'h33, 1'b1, 8'h00); req_valid = 4'b0100;
        observe_txn(1, 150, o);
`ifdef I2C_ARB_TIMEOUT_EN
        n_cmp++; if (o.abort_cyc !== o.st_cyc + TCYC) begin n_bad++; $display("FAIL tmo_abort got %0d want %0d", o.abort_cyc - o.st_cyc, TCYC); end
        n_cmp++; if (!o.got_rsp || o.vld !== 4'b0100 || o.rsp_cyc !== o.st_cyc + TCYC + 1) begin n_bad++; $display("FAIL tmo_rsp got %b@%0d want 0100@%0d", o.vld, o.rsp_cyc - o.st_cyc, TCYC + 1); end
        n_cmp++; if (o.tmo !== 1'b1 || o.rdata !== 8'h00) begin n_bad++; $display("FAIL tmo_fields got %b/%h want 1/00", o.tmo, o.rdata); end
`else
        n_cmp++; if (o.got_rsp) begin n_bad++; $display("FAIL tmo_none got rsp %b want none", o.vld); end
        n_cmp++; if (o.abort_cyc !== -1 || !o.got_start) begin n_bad++; $display("FAIL tmo_noabort got abort@%0d start=%b want none/1", o.abort_cyc, o.got_start); end
`endif
        stuck = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_nack();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
